// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
//   Scan controller for the 4-digit common-anode FND.
//   - Converts a 14-bit binary value (saturated to 9999) to BCD with a
//     multi-cycle double-dabble FSM. The result is committed to a display
//     register in one step.
//   - Time-multiplexes the four digits.
//   - Supports leading-zero blanking, per-digit decimal points and
//     whole-display blink.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   single-cycle strobe: capture value, start conversion
//   value     in   [13:0] binary value; values above 9999 show as 9999
//   dp_en     in   [3:0] decimal point enable per digit (bit 0 = ones)
//   blank_lz  in   1 = blank leading zeros
//   blink_en  in   1 = whole display blinks at BLINK_HZ
//   busy      out  conversion in progress; load is ignored while high
//   digit_sel out  [1:0] digit index to the 2-to-4 decoder (0 = ones)
//   seg       out  [7:0] active-low {dp,g,f,e,d,c,b,a}
module fnd_scan_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic        busy,
  output logic [1:0]  digit_sel,
  output logic [7:0]  seg
);

  localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [13:0] VAL_MAX = 14'd9999;

  // Conversion state
  logic [1:0]  state_q, state_d;
  logic [3:0]  iter_q, iter_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] bcd_adj;
  logic        busy_q, busy_d;
  logic [15:0] disp_q, disp_d;

  // Scan and blink state
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [7:0]         seg_q, seg_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_on_q, phase_on_d;

  logic       refresh;
  logic [1:0] sel_nxt;
  logic [3:0] digit;
  logic [7:0] pat;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 8'hC0;
      4'd1:    seg_enc = 8'hF9;
      4'd2:    seg_enc = 8'hA4;
      4'd3:    seg_enc = 8'hB0;
      4'd4:    seg_enc = 8'h99;
      4'd5:    seg_enc = 8'h92;
      4'd6:    seg_enc = 8'h82;
      4'd7:    seg_enc = 8'hF8;
      4'd8:    seg_enc = 8'h80;
      4'd9:    seg_enc = 8'h90;
      default: seg_enc = 8'hFF;
    endcase
  endfunction

  // True when digit i and every digit above it are zero. Digit 0 is never
  // considered leading, so a zero value still shows "0".
  function automatic logic is_leading_zero(input logic [15:0] d,
                                           input logic [1:0]  i);
    case (i)
      2'd1:    is_leading_zero = (d[15:4]  == 12'd0);
      2'd2:    is_leading_zero = (d[15:8]  == 8'd0);
      2'd3:    is_leading_zero = (d[15:12] == 4'd0);
      default: is_leading_zero = 1'b0;
    endcase
  endfunction

  // Double-dabble adjust step: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM. SHIFT runs 14 shift cycles and then one extra cycle
  // that moves to COMMIT and drops busy. The display register therefore
  // updates 16 edges after the edge that accepted load. Load is ignored
  // during COMMIT because only IDLE looks at it.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d   = (value > VAL_MAX) ? VAL_MAX : value;
          bcd_d   = 16'd0;
          iter_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (iter_q == 4'd14) begin
          busy_d  = 1'b0;
          state_d = S_COMMIT;
        end else begin
          bcd_d  = {bcd_adj[14:0], bin_q[13]};
          bin_d  = {bin_q[12:0], 1'b0};
          iter_d = iter_q + 4'd1;
        end
      end
      S_COMMIT: begin
        disp_d  = bcd_q;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Scan: seg is recomputed only on the refresh edge, for the digit that
  // becomes selected on that same edge. Display options are sampled here.
  always_comb begin
    refresh    = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = refresh ? '0 : scan_cnt_q + SCAN_W'(1);
    sel_nxt    = sel_q + 2'd1;
    digit      = disp_q[{sel_nxt, 2'b00} +: 4];

    pat = seg_enc(digit);
    if (blank_lz && is_leading_zero(disp_q, sel_nxt)) begin
      pat = 8'hFF;
    end
    if (dp_en[sel_nxt]) begin
      pat[7] = 1'b0;
    end
    if (blink_en && !phase_on_q) begin
      pat = 8'hFF;
    end

    sel_d = refresh ? sel_nxt : sel_q;
    seg_d = refresh ? pat : seg_q;
  end

  // Blink phase. Disabling clears the counter so a re-enable always starts
  // with a full on phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_on_d  = !phase_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      iter_q      <= 4'd0;
      bin_q       <= 14'd0;
      bcd_q       <= 16'd0;
      busy_q      <= 1'b0;
      disp_q      <= 16'd0;
      scan_cnt_q  <= '0;
      sel_q       <= 2'd0;
      seg_q       <= 8'hFF;
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      busy_q      <= busy_d;
      disp_q      <= disp_d;
      scan_cnt_q  <= scan_cnt_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      blink_cnt_q <= blink_cnt_d;
      phase_on_q  <= phase_on_d;
    end
  end

  assign busy      = busy_q;
  assign digit_sel = sel_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

  localparam int CLK_HZ     = 1000;
  localparam int SCAN_HZ    = 100;
  localparam int BLINK_HZ   = 25;
  localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [13:0] value;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic        blink_en;
  logic        busy;
  logic [1:0]  digit_sel;
  logic [7:0]  seg;

  fnd_scan_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .SCAN_HZ  (SCAN_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .dp_en     (dp_en),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .busy      (busy),
    .digit_sel (digit_sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time is counted in edges since reset release, the
  // display is held as a decimal integer, and a conversion is simply a
  // pending value with a commit deadline.
  int         m_n;
  int         m_disp;
  int         m_pend;
  int         m_start;
  int         m_val;
  int         m_ncyc;
  logic [1:0] m_sel;
  logic [7:0] m_seg;
  logic       m_busy;

  logic [7:0] enc_tbl [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  task automatic model_reset();
    m_n    = 0;
    m_disp = 0;
    m_pend = 0;
    m_start = 0;
    m_val  = 0;
    m_ncyc = 0;
    m_sel  = 2'd0;
    m_seg  = 8'hFF;
    m_busy = 1'b0;
  endtask

  task automatic model_edge();
    bit phase_on;
    int d;
    if (rst_n) begin
      m_n++;
      phase_on = ((m_ncyc / BLINK_HALF) % 2) == 0;
      if ((m_n % SCAN_DIV) == 0) begin
        d     = (m_n / SCAN_DIV) % 4;
        m_sel = 2'(d);
        if (blink_en && !phase_on) begin
          m_seg = 8'hFF;
        end else begin
          if (blank_lz && d > 0 && m_disp < pow10(d)) m_seg = 8'hFF;
          else m_seg = enc_tbl[(m_disp / pow10(d)) % 10];
          if (dp_en[d]) m_seg[7] = 1'b0;
        end
      end
      if (load && m_pend == 0) begin
        m_pend  = 1;
        m_start = m_n;
        m_val   = (int'(value) > 9999) ? 9999 : int'(value);
      end else if (m_pend != 0 && m_n == m_start + 16) begin
        m_disp = m_val;
        m_pend = 0;
      end
      m_busy = (m_pend != 0) && (m_n < m_start + 15);
      m_ncyc = blink_en ? m_ncyc + 1 : 0;
    end
  endtask

  task automatic compare();
    chk("digit_sel", 32'(digit_sel), 32'(m_sel));
    chk("seg",       32'(seg),       32'(m_seg));
    chk("busy",      32'(busy),      32'(m_busy));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic pulse_load(input logic [13:0] v);
    value = v;
    load  = 1'b1;
    run(1);
    load  = 1'b0;
  endtask

  initial begin
    enc_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 14'd0;
    dp_en    = 4'd0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    model_reset();
    run(3);
    // Reset state, checked against constants.
    chk("rst_seg", 32'(seg), 32'h0000_00FF);
    chk("rst_sel", 32'(digit_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // 1: idle scan of 0000
    run(40);

    // 2: 1234
    pulse_load(14'd1234);
    chk("busy_after_load", 32'(busy), 32'd1);
    run(14);
    chk("busy_last_cycle", 32'(busy), 32'd1);
    run(1);
    chk("busy_dropped", 32'(busy), 32'd0);
    run(45);

    // 3: blanking and decimal point
    blank_lz = 1'b1;
    dp_en    = 4'b0100;
    pulse_load(14'd7);
    run(60);
    pulse_load(14'd0);
    run(60);
    pulse_load(14'd1005);
    run(60);

    // 4: saturation, load while busy ignored
    blank_lz = 1'b0;
    dp_en    = 4'd0;
    pulse_load(14'd16383);
    run(4);
    pulse_load(14'd1111);
    run(60);

    // load held over the COMMIT cycle: ignored there, accepted in first IDLE
    pulse_load(14'd2468);
    run(15);
    value = 14'd8642;
    load  = 1'b1;
    run(2);
    load  = 1'b0;
    run(60);

    // 5: blink, then drop it during an off phase
    blink_en = 1'b1;
    run(100);
    for (int i = 0; i < 60 && ((m_ncyc / BLINK_HALF) % 2) == 0; i++) run(1);
    blink_en = 1'b0;
    run(30);

    // 6: reset in the middle of a conversion
    pulse_load(14'd4321);
    run(7);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    run(3);
    rst_n = 1'b1;
    run(60);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      load = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 3) == 0) value = 14'($urandom_range(9990, 16383));
      else value = 14'($urandom_range(0, 9999));
      if ($urandom_range(0, 99) < 2) blank_lz = ~blank_lz;
      if ($urandom_range(0, 99) < 2) dp_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) < 2) blink_en = ~blink_en;
      run(1);
    end
    load = 1'b0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
